// File: rtl/param_data_memory.sv
// Byte-addressed data memory with byte/halfword/word access, error reporting,
// a configurable registered read latency and a zero-fill sweep after reset.
module param_data_memory #(
   parameter int DEPTH    = 256,
   parameter int ADDR_W   = 32,
   parameter int READ_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   output logic              busy
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   state_t state_q, state_d;
   logic [IDX_W-1:0] clear_idx_q, clear_idx_d;

   logic [31:0] mem_q [DEPTH];

   logic [READ_LAT-1:0]       pipe_valid_q, pipe_valid_d;
   logic [READ_LAT-1:0]       pipe_err_q, pipe_err_d;
   logic [READ_LAT-1:0][31:0] pipe_data_q, pipe_data_d;

   logic [IDX_W-1:0] word_idx;
   logic [1:0]       lane;
   logic [31:0]      rd_word;
   logic [31:0]      shifted;
   logic             accept;
   logic             out_of_range;
   logic             req_err;
   logic [31:0]      load_data;
   logic [3:0]       byte_en;
   logic [31:0]      store_data;
   logic [31:0]      lane_mask;

   logic             mem_we;
   logic [IDX_W-1:0] mem_widx;
   logic [31:0]      mem_wword;

   // Address bits above the memory's word index make the access out of range.
   if (ADDR_W - 2 > IDX_W) begin : g_range
      assign out_of_range = |req_addr[ADDR_W-1:IDX_W+2];
   end else begin : g_no_range
      assign out_of_range = 1'b0;
   end

   always_comb begin
      word_idx   = req_addr[IDX_W+1:2];
      lane       = req_addr[1:0];
      rd_word    = mem_q[word_idx];
      shifted    = rd_word >> {lane, 3'b000};
      accept     = req_valid && (state_q == ST_IDLE);
      req_err    = (req_size == 2'b11)
                 || ((req_size == 2'b01) && req_addr[0])
                 || ((req_size == 2'b10) && (lane != 2'b00))
                 || out_of_range;
      load_data  = '0;
      byte_en    = '0;
      store_data = '0;
      case (req_size)
         2'b00: begin
            load_data  = {{24{req_signed & shifted[7]}}, shifted[7:0]};
            byte_en    = 4'b0001 << lane;
            store_data = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            load_data  = {{16{req_signed & shifted[15]}}, shifted[15:0]};
            byte_en    = 4'b0011 << lane;
            store_data = {2{req_wdata[15:0]}};
         end
         2'b10: begin
            load_data  = rd_word;
            byte_en    = 4'b1111;
            store_data = req_wdata;
         end
         default: ;
      endcase
      lane_mask = {{8{byte_en[3]}}, {8{byte_en[2]}}, {8{byte_en[1]}}, {8{byte_en[0]}}};
   end

   // Stores merge the new lanes into the current word so one full-word write
   // port serves both the clear sweep and partial-width stores.
   always_comb begin
      state_d     = state_q;
      clear_idx_d = clear_idx_q;
      mem_we      = 1'b0;
      mem_widx    = word_idx;
      mem_wword   = (rd_word & ~lane_mask) | (store_data & lane_mask);
      case (state_q)
         ST_CLEAR: begin
            mem_we      = 1'b1;
            mem_widx    = clear_idx_q;
            mem_wword   = '0;
            clear_idx_d = clear_idx_q + 1'b1;
            if (clear_idx_q == LAST_IDX) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            mem_we = accept && req_write && !req_err;
         end
         default: begin
            state_d = ST_CLEAR;
         end
      endcase
   end

   // Stage 0 captures the response at acceptance; data and error stay zero
   // in empty slots so the outputs need no gating.
   always_comb begin
      pipe_valid_d    = '0;
      pipe_err_d      = '0;
      pipe_data_d     = '0;
      pipe_valid_d[0] = accept;
      pipe_err_d[0]   = accept && req_err;
      pipe_data_d[0]  = (accept && !req_write && !req_err) ? load_data : 32'h0;
      for (int i = 1; i < READ_LAT; i++) begin
         pipe_valid_d[i] = pipe_valid_q[i-1];
         pipe_err_d[i]   = pipe_err_q[i-1];
         pipe_data_d[i]  = pipe_data_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_CLEAR;
         clear_idx_q  <= '0;
         pipe_valid_q <= '0;
         pipe_err_q   <= '0;
         pipe_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         clear_idx_q  <= clear_idx_d;
         pipe_valid_q <= pipe_valid_d;
         pipe_err_q   <= pipe_err_d;
         pipe_data_q  <= pipe_data_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_widx] <= mem_wword;
      end
   end

   assign rsp_valid = pipe_valid_q[READ_LAT-1];
   assign rsp_err   = pipe_err_q[READ_LAT-1];
   assign rsp_rdata = pipe_data_q[READ_LAT-1];
   assign busy      = (state_q == ST_CLEAR);
   assign req_ready = (state_q == ST_IDLE);

endmodule

// File: tb/tb_param_data_memory.sv
// Self-checking bench for param_data_memory: directed vector table, back-to-back
// burst, reset corner cases and randomized traffic against a byte-level model.
module tb_param_data_memory;

   localparam int DEPTH    = 16;
   localparam int ADDR_W   = 32;
   localparam int READ_LAT = 3;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_write = 1'b0;
   logic [1:0]        req_size = 2'b00;
   logic              req_signed = 1'b0;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [31:0]       req_wdata = '0;
   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_err;
   logic              busy;

   always #5 clk = ~clk;

   param_data_memory #(
      .DEPTH   (DEPTH),
      .ADDR_W  (ADDR_W),
      .READ_LAT(READ_LAT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_size  (req_size),
      .req_signed(req_signed),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .busy      (busy)
   );

   typedef struct packed {
      logic        write;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   typedef struct packed {
      logic        valid;
      logic        write;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   int          tests_run = 0;
   int          tests_failed = 0;
   logic [31:0] ref_mem [DEPTH];
   req_t        seq_q [$];
   logic [31:0] rsp_log [$];

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Reference model: treats memory as bytes and assembles little-endian values.
   function automatic void model_access(input logic wr, input logic [1:0] sz, input logic sg,
                                        input logic [31:0] addr, input logic [31:0] wd,
                                        output logic [31:0] rd, output logic err);
      int          nbytes;
      int unsigned a;
      nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      err    = (sz == 2'd3) || ((addr % nbytes) != 0) || ((addr / 4) >= DEPTH);
      rd     = '0;
      if (err) return;
      for (int b = 0; b < nbytes; b++) begin
         a = addr + b;
         if (wr) ref_mem[a / 4][(a % 4) * 8 +: 8] = wd[b * 8 +: 8];
         else    rd[b * 8 +: 8] = ref_mem[a / 4][(a % 4) * 8 +: 8];
      end
      if (!wr && sg && nbytes < 4 && rd[nbytes * 8 - 1]) rd = rd | (32'hFFFF_FFFF << (nbytes * 8));
   endfunction

   function automatic vec_t mk_vec(input logic wr, input logic [1:0] sz, input logic sg,
                                   input logic [31:0] addr, input logic [31:0] wd,
                                   input logic [31:0] exp_rd, input logic exp_err);
      vec_t v;
      v = '{write: wr, size: sz, sgn: sg, addr: addr, wdata: wd, exp_rd: exp_rd, exp_err: exp_err};
      return v;
   endfunction

   function automatic req_t rand_req();
      req_t r;
      int   pick;
      int   nbytes;
      r.valid = ($urandom_range(0, 3) != 0);
      r.write = 1'($urandom_range(0, 1));
      r.sgn   = 1'($urandom_range(0, 1));
      r.wdata = $urandom;
      pick    = $urandom_range(0, 15);
      r.size  = (pick < 5) ? 2'd0 : (pick < 10) ? 2'd1 : (pick < 15) ? 2'd2 : 2'd3;
      nbytes  = (r.size == 2'd0) ? 1 : (r.size == 2'd1) ? 2 : 4;
      r.addr  = $urandom_range(0, DEPTH * 4 - 1);
      if ($urandom_range(0, 3) != 0) r.addr = r.addr - (r.addr % nbytes);
      if ($urandom_range(0, 15) == 0) r.addr = DEPTH * 4 + $urandom_range(0, 255);
      return r;
   endfunction

   // Issues one request and samples the response after each of READ_LAT edges.
   task automatic applyStimulus(input logic wr, input logic [1:0] sz, input logic sg,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output logic [31:0] rd, output logic err, output logic [3:0] seen);
      checkOutput("req_ready_at_issue", 64'(req_ready), 64'd1);
      req_valid  = 1'b1;
      req_write  = wr;
      req_size   = sz;
      req_signed = sg;
      req_addr   = addr;
      req_wdata  = wd;
      seen       = '0;
      for (int k = 1; k <= READ_LAT; k++) begin
         @(posedge clk);
         #1;
         if (k == 1) req_valid = 1'b0;
         seen[k-1] = rsp_valid;
      end
      rd  = rsp_rdata;
      err = rsp_err;
   endtask

   task automatic wait_sweep(input string tag);
      int   cnt;
      logic ready_bad;
      logic rsp_bad;
      cnt       = 0;
      ready_bad = 1'b0;
      rsp_bad   = 1'b0;
      while (busy && cnt < 4 * DEPTH) begin
         if (req_ready) ready_bad = 1'b1;
         if (rsp_valid) rsp_bad = 1'b1;
         @(posedge clk);
         #1;
         cnt++;
      end
      checkOutput({tag, "_busy_cycles"}, 64'(cnt), 64'(DEPTH));
      checkOutput({tag, "_ready_while_busy"}, 64'(ready_bad), 64'd0);
      checkOutput({tag, "_rsp_while_busy"}, 64'(rsp_bad), 64'd0);
      checkOutput({tag, "_ready_after"}, 64'(req_ready), 64'd1);
   endtask

   // Streams seq_q one slot per cycle and checks every cycle's outputs against
   // responses the model scheduled READ_LAT edges after acceptance.
   task automatic run_seq(input string tag);
      int          due_q [$];
      logic [31:0] erd_q [$];
      logic        eerr_q [$];
      logic [31:0] m_rd;
      logic        m_err;
      int          total;
      total = seq_q.size() + READ_LAT + 1;
      rsp_log.delete();
      for (int c = 0; c < total; c++) begin
         if (c < seq_q.size() && seq_q[c].valid) begin
            req_valid  = 1'b1;
            req_write  = seq_q[c].write;
            req_size   = seq_q[c].size;
            req_signed = seq_q[c].sgn;
            req_addr   = seq_q[c].addr;
            req_wdata  = seq_q[c].wdata;
            model_access(seq_q[c].write, seq_q[c].size, seq_q[c].sgn, seq_q[c].addr,
                         seq_q[c].wdata, m_rd, m_err);
            due_q.push_back(c + READ_LAT - 1);
            erd_q.push_back(m_rd);
            eerr_q.push_back(m_err);
         end else begin
            req_valid = 1'b0;
         end
         @(posedge clk);
         #1;
         if (due_q.size() > 0 && due_q[0] == c) begin
            checkOutput($sformatf("%s_c%0d_rsp", tag, c), {31'd0, rsp_valid, rsp_err, rsp_rdata},
                        {31'd0, 1'b1, eerr_q[0], erd_q[0]});
            rsp_log.push_back(rsp_rdata);
            void'(due_q.pop_front());
            void'(erd_q.pop_front());
            void'(eerr_q.pop_front());
         end else begin
            checkOutput($sformatf("%s_c%0d_quiet", tag, c), {31'd0, rsp_valid, rsp_err, rsp_rdata}, 64'd0);
         end
      end
      req_valid = 1'b0;
   endtask

   initial begin
      #500_000;
      $display("[TB] FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t        vecs [20];
      logic [31:0] got_rd;
      logic        got_err;
      logic [3:0]  seen;
      logic [31:0] m_rd;
      logic        m_err;
      logic        rsp_bad;

      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

      vecs[0]  = mk_vec(1'b0, 2'd2, 1'b0, 32'h3C, 32'h0,         32'h0000_0000, 1'b0);
      vecs[1]  = mk_vec(1'b1, 2'd2, 1'b0, 32'h10, 32'h8040_20F1, 32'h0000_0000, 1'b0);
      vecs[2]  = mk_vec(1'b1, 2'd0, 1'b0, 32'h12, 32'h0000_00AA, 32'h0000_0000, 1'b0);
      vecs[3]  = mk_vec(1'b0, 2'd2, 1'b0, 32'h10, 32'h0,         32'h80AA_20F1, 1'b0);
      vecs[4]  = mk_vec(1'b0, 2'd0, 1'b1, 32'h13, 32'h0,         32'hFFFF_FF80, 1'b0);
      vecs[5]  = mk_vec(1'b0, 2'd0, 1'b0, 32'h13, 32'h0,         32'h0000_0080, 1'b0);
      vecs[6]  = mk_vec(1'b0, 2'd1, 1'b1, 32'h10, 32'h0,         32'h0000_20F1, 1'b0);
      vecs[7]  = mk_vec(1'b0, 2'd1, 1'b0, 32'h12, 32'h0,         32'h0000_80AA, 1'b0);
      vecs[8]  = mk_vec(1'b1, 2'd2, 1'b0, 32'h11, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1);
      vecs[9]  = mk_vec(1'b0, 2'd1, 1'b0, 32'h13, 32'h0,         32'h0000_0000, 1'b1);
      vecs[10] = mk_vec(1'b0, 2'd3, 1'b0, 32'h10, 32'h0,         32'h0000_0000, 1'b1);
      vecs[11] = mk_vec(1'b0, 2'd2, 1'b0, 32'h40, 32'h0,         32'h0000_0000, 1'b1);
      vecs[12] = mk_vec(1'b1, 2'd3, 1'b0, 32'h10, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
      vecs[13] = mk_vec(1'b0, 2'd2, 1'b0, 32'h10, 32'h0,         32'h80AA_20F1, 1'b0);
      vecs[14] = mk_vec(1'b0, 2'd1, 1'b1, 32'h12, 32'h0,         32'hFFFF_80AA, 1'b0);
      vecs[15] = mk_vec(1'b1, 2'd2, 1'b0, 32'h40, 32'h1234_5678, 32'h0000_0000, 1'b1);
      vecs[16] = mk_vec(1'b0, 2'd2, 1'b0, 32'h00, 32'h0,         32'h0000_0000, 1'b0);
      vecs[17] = mk_vec(1'b1, 2'd1, 1'b0, 32'h0E, 32'hBEEF_1234, 32'h0000_0000, 1'b0);
      vecs[18] = mk_vec(1'b0, 2'd2, 1'b0, 32'h0C, 32'h0,         32'h1234_0000, 1'b0);
      vecs[19] = mk_vec(1'b0, 2'd0, 1'b1, 32'h0E, 32'h0,         32'h0000_0034, 1'b0);

      #2;
      reset = 1'b0;
      #1;
      checkOutput("reset_outputs", {31'd0, rsp_valid, rsp_err, req_ready, rsp_rdata}, 64'd0);
      checkOutput("reset_busy", 64'(busy), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      wait_sweep("init_sweep");

      for (int i = 0; i < 20; i++) begin
         model_access(vecs[i].write, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata, m_rd, m_err);
         applyStimulus(vecs[i].write, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                       got_rd, got_err, seen);
         checkOutput($sformatf("vec%0d_latency", i), 64'(seen), 64'(1 << (READ_LAT - 1)));
         checkOutput($sformatf("vec%0d_rdata", i), 64'(got_rd), 64'(vecs[i].exp_rd));
         checkOutput($sformatf("vec%0d_err", i), 64'(got_err), 64'(vecs[i].exp_err));
      end

      seq_q.delete();
      seq_q.push_back('{valid: 1'b1, write: 1'b1, size: 2'd2, sgn: 1'b0, addr: 32'h20, wdata: 32'h1111_2222});
      seq_q.push_back('{valid: 1'b1, write: 1'b0, size: 2'd2, sgn: 1'b0, addr: 32'h20, wdata: 32'h0});
      seq_q.push_back('{valid: 1'b1, write: 1'b1, size: 2'd2, sgn: 1'b0, addr: 32'h24, wdata: 32'h3333_4444});
      seq_q.push_back('{valid: 1'b1, write: 1'b0, size: 2'd2, sgn: 1'b0, addr: 32'h24, wdata: 32'h0});
      run_seq("burst");
      checkOutput("burst_rsp_count", 64'(rsp_log.size()), 64'd4);
      checkOutput("burst_load0", 64'(rsp_log[1]), 64'h1111_2222);
      checkOutput("burst_load1", 64'(rsp_log[3]), 64'h3333_4444);

      seq_q.delete();
      for (int i = 0; i < 300; i++) seq_q.push_back(rand_req());
      run_seq("rand");

      // Reset with READ_LAT loads outstanding: the first response is visible
      // at the moment reset hits, the rest must never appear.
      model_access(1'b1, 2'd2, 1'b0, 32'h10, 32'hCAFE_F00D, m_rd, m_err);
      applyStimulus(1'b1, 2'd2, 1'b0, 32'h10, 32'hCAFE_F00D, got_rd, got_err, seen);
      for (int k = 0; k < READ_LAT; k++) begin
         req_valid  = 1'b1;
         req_write  = 1'b0;
         req_size   = 2'd2;
         req_signed = 1'b0;
         req_addr   = 32'h10;
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      checkOutput("inflight_first_rsp", {31'd0, rsp_valid, rsp_err, rsp_rdata}, {31'd0, 1'b1, 1'b0, 32'hCAFE_F00D});
      reset = 1'b0;
      #1;
      checkOutput("inflight_reset_outputs", {31'd0, rsp_valid, rsp_err, req_ready, rsp_rdata}, 64'd0);
      checkOutput("inflight_reset_busy", 64'(busy), 64'd1);
      rsp_bad = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (rsp_valid) rsp_bad = 1'b1;
      end
      reset = 1'b1;
      checkOutput("inflight_rsp_during_reset", 64'(rsp_bad), 64'd0);
      wait_sweep("inflight_sweep");
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      applyStimulus(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, got_rd, got_err, seen);
      checkOutput("cleared_word_0x10", 64'(got_rd), 64'd0);

      applyStimulus(1'b1, 2'd2, 1'b0, 32'h08, 32'h5A5A_A5A5, got_rd, got_err, seen);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("midsweep_busy", 64'(busy), 64'd1);
      reset = 1'b0;
      #1;
      checkOutput("midsweep_reset_outputs", {31'd0, rsp_valid, rsp_err, req_ready, rsp_rdata}, 64'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      wait_sweep("midsweep");
      applyStimulus(1'b0, 2'd2, 1'b0, 32'h08, 32'h0, got_rd, got_err, seen);
      checkOutput("cleared_word_0x08", 64'(got_rd), 64'd0);

      seq_q.delete();
      for (int i = 0; i < 60; i++) seq_q.push_back(rand_req());
      run_seq("post");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
